// File: rtl/chess_pkg.sv
// Shared chess encodings for the rook move executor: square bits, colours,
// move directions and controller states.
package chess_pkg;
  localparam int STEP_LIMIT = 7;

  localparam int OCC  = 0;
  localparam int COL  = 1;
  localparam int KING = 2;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;
  typedef enum logic [2:0] {IDLE, CHECK, SCAN, WR_SRC, WR_DST, DONE} state_t;

  function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/rook_path_step.sv
// Combinational square locator: the square k steps from (row, col) along dir.
module rook_path_step
  import chess_pkg::*;
(
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  input  dir_t       i_dir,
  input  logic [2:0] i_k,
  output logic [2:0] o_row,
  output logic [2:0] o_col
);
  always_comb begin
    o_row = i_row;
    o_col = i_col;
    case (i_dir)
      UP:    o_row = i_row - i_k;
      DOWN:  o_row = i_row + i_k;
      LEFT:  o_col = i_col - i_k;
      RIGHT: o_col = i_col + i_k;
    endcase
  end
endmodule

// File: rtl/rook_move_exec.sv
// Rook move executor: validates a requested move, walks the path for blockers
// (allow distances pass through opponents) and commits it with two board writes.
module rook_move_exec
  import chess_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            srcRow,
  input  logic [2:0]            srcCol,
  input  logic [2:0]            dstRow,
  input  logic [2:0]            dstCol,
  input  logic                  color,
  input  logic [2:0]            rookAllowUp,
  input  logic [2:0]            rookAllowRight,
  input  logic [2:0]            rookAllowDown,
  input  logic [2:0]            rookAllowLeft,
  input  logic [7:0][7:0][2:0]  boardPos,
  output logic                  busy,
  output logic                  done,
  output logic                  legal,
  output logic                  capture,
  output logic                  captureKing,
  output logic                  wrEn,
  output logic [2:0]            wrRow,
  output logic [2:0]            wrCol,
  output logic [2:0]            wrData
);
  state_t           r_state, w_next;
  logic [2:0]       r_srcRow, r_srcCol, r_dstRow, r_dstCol;
  logic             r_color;
  logic [3:0][2:0]  r_allow;
  dir_t             r_dir, w_dir;
  logic [2:0]       r_dist, w_dist, r_k;
  logic             r_legal, r_capture, r_king;

  logic             w_rowEq, w_colEq, w_checkOk, w_dstCap;
  logic [2:0]       w_srcSq, w_dstSq, w_scanSq;
  logic [2:0]       w_endRow, w_endCol, w_scanRow, w_scanCol;

  assign w_rowEq  = (r_srcRow == r_dstRow);
  assign w_colEq  = (r_srcCol == r_dstCol);
  assign w_dir    = w_rowEq ? ((r_dstCol < r_srcCol) ? LEFT : RIGHT)
                            : ((r_dstRow < r_srcRow) ? UP : DOWN);
  assign w_dist   = w_rowEq ? abs_diff(r_srcCol, r_dstCol) : abs_diff(r_srcRow, r_dstRow);
  assign w_srcSq  = boardPos[r_srcRow][r_srcCol];
  assign w_dstSq  = boardPos[r_dstRow][r_dstCol];
  assign w_scanSq = boardPos[w_scanRow][w_scanCol];
  assign w_dstCap = w_dstSq[OCC] & (w_dstSq[COL] != r_color);

  rook_path_step u_end_step (
    .i_row(r_srcRow), .i_col(r_srcCol), .i_dir(w_dir), .i_k(w_dist),
    .o_row(w_endRow), .o_col(w_endCol)
  );

  rook_path_step u_scan_step (
    .i_row(r_srcRow), .i_col(r_srcCol), .i_dir(r_dir), .i_k(r_k),
    .o_row(w_scanRow), .o_col(w_scanCol)
  );

  // Walking the path to the end square is a cross-check on the direction/distance decode.
  assign w_checkOk = (w_srcSq[1:0] == {r_color, 1'b1})
                   && !(w_rowEq && w_colEq)
                   && (w_rowEq || w_colEq)
                   && (w_dist <= r_allow[w_dir])
                   && !(w_dstSq[OCC] && (w_dstSq[COL] == r_color))
                   && (w_endRow == r_dstRow) && (w_endCol == r_dstCol);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_srcRow  <= '0;
      r_srcCol  <= '0;
      r_dstRow  <= '0;
      r_dstCol  <= '0;
      r_color   <= WHITE;
      r_allow   <= '0;
      r_dir     <= UP;
      r_dist    <= '0;
      r_k       <= '0;
      r_legal   <= 1'b0;
      r_capture <= 1'b0;
      r_king    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_srcRow  <= srcRow;
          r_srcCol  <= srcCol;
          r_dstRow  <= dstRow;
          r_dstCol  <= dstCol;
          r_color   <= color;
          r_allow   <= {rookAllowLeft, rookAllowDown, rookAllowRight, rookAllowUp};
          r_legal   <= 1'b0;
          r_capture <= 1'b0;
          r_king    <= 1'b0;
        end
        CHECK: begin
          r_dir     <= w_dir;
          r_dist    <= w_dist;
          r_k       <= 3'd1;
          r_legal   <= w_checkOk;
          r_capture <= w_dstCap;
          r_king    <= w_dstCap & w_dstSq[KING];
        end
        SCAN: begin
          if (w_scanSq[OCC]) r_legal <= 1'b0;
          else               r_k     <= r_k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = 1'b0;
    wrEn   = 1'b0;
    wrRow  = '0;
    wrCol  = '0;
    wrData = '0;
    case (r_state)
      IDLE:   if (start) w_next = CHECK;
      CHECK: begin
        if (!w_checkOk)       w_next = DONE;
        else if (w_dist > 3'd1) w_next = SCAN;
        else                  w_next = WR_SRC;
      end
      SCAN: begin
        if (w_scanSq[OCC])              w_next = DONE;
        else if (r_k == r_dist - 3'd1)  w_next = WR_SRC;
      end
      WR_SRC: begin
        wrEn   = 1'b1;
        wrRow  = r_srcRow;
        wrCol  = r_srcCol;
        w_next = WR_DST;
      end
      WR_DST: begin
        wrEn   = 1'b1;
        wrRow  = r_dstRow;
        wrCol  = r_dstCol;
        wrData = {1'b0, r_color, 1'b1};
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign legal       = done & r_legal;
  assign capture     = done & r_legal & r_capture;
  assign captureKing = done & r_legal & r_king;
endmodule

// File: doc/rook_move_exec.md
Name: rook_move_exec

Overview:
- Downstream consumer of the rook allowed-distance outputs (rookAllowUp/Right/Down/Left).
- Given a requested rook move, the block:
  - checks that the move is on the same row or column and within the allowed distance;
  - walks the intermediate squares one per cycle, because the distance values stop only at own-colour pieces and do not stop at opponent pieces;
  - flags a capture;
  - commits the move to the board store with two write cycles.
- Sits between the move-request front end and the board register file.

Parameters:
- STEP_LIMIT, 7, maximum path length in squares; fixed by the board size and not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- srcRow, srcCol  input  3 each  rook square; row 0 is the top row, column 0 is the left column.
- dstRow, dstCol  input  3 each  destination square.
- color  input  1  mover colour; black = 1, white = 0.
- rookAllowUp, rookAllowRight, rookAllowDown, rookAllowLeft  input  3 each  allowed distances for the source square.
- boardPos  input  3 x [7:0][7:0]  live board. Per square: bit0 = occupied, bit1 = colour, bit2 = king.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of every request.
- legal  output  1  valid while done is high; 1 = move committed.
- capture  output  1  valid with done; destination held an opponent piece.
- captureKing  output  1  valid with done; the captured piece had bit2 set.
- wrEn  output  1  board write strobe.
- wrRow, wrCol  output  3 each  write address.
- wrData  output  3  write data.

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE;
  - busy, done, legal, capture, captureKing and wrEn go to 0;
  - wrRow, wrCol, wrData and all latched fields go to 0.
- IDLE:
  - start = 1 latches src, dst, color and the four allow values;
  - next state is CHECK.
  - start while busy is ignored; no queueing.
- CHECK (1 cycle). The request is illegal, and the next state is DONE, if any of these hold:
  - boardPos[src][1:0] != {color,1};
  - src == dst;
  - neither the rows nor the columns are equal.
- CHECK direction and distance, where d = |delta|:
  - direction is Up if dstRow < srcRow, Down if dstRow > srcRow, Left if dstCol < srcCol, Right if dstCol > srcCol;
  - the move is illegal if d > allow[direction];
  - the move is illegal if the destination holds own colour (defensive, even though the allow value already covers it).
- CHECK outcome when legal so far:
  - captureReg = dst bit0 & (dst bit1 != color);
  - kingReg = captureReg & dst bit2;
  - next state is SCAN if d > 1, otherwise WR_SRC.
- SCAN:
  - step counter k starts at 1;
  - each cycle examines the square k steps from src in the chosen direction;
  - if that square is occupied, the move is illegal and the next state is DONE;
  - otherwise k increments, and the next state is WR_SRC once k == d-1 has been examined.
  - The 3-bit arithmetic never wraps, because d <= 7 and k < d.
- WR_SRC (1 cycle): wrEn = 1, address = src, wrData = 3'b000.
- WR_DST (1 cycle): wrEn = 1, address = dst, wrData = {1'b0, color, 1'b1}.
- DONE (1 cycle), then IDLE:
  - done = 1;
  - legal, capture and captureKing are driven from registers;
  - capture and captureKing are forced to 0 when legal = 0.
- Latency, counting clock edges after the edge that samples start:
  - illegal in CHECK: done high after 2 edges;
  - blocked at step k: done high after k+2 edges;
  - legal move of distance d: done high after d+3 edges.
- wrEn is high only in WR_SRC and WR_DST. An illegal request never writes.
- boardPos is read live. It must be stable while busy, because this block is the sole board writer during a move.
- Reset between WR_SRC and WR_DST leaves the board with the piece removed. Board reset is tied to the same reset line, so the system-level reset recovers it.
- start held high through DONE starts a new request only after returning to IDLE, i.e. on the next sampled edge.

Decomposition:
- chess_pkg holds:
  - square-bit index constants OCC = 0, COL = 1, KING = 2;
  - colour constants WHITE = 0, BLACK = 1;
  - dir_t enum {UP, RIGHT, DOWN, LEFT};
  - state_t enum {IDLE, CHECK, SCAN, WR_SRC, WR_DST, DONE}.
- One sub-module: rook_path_step. It is combinational and returns the square (row, col) k steps from src in direction dir. It is used for both the SCAN address and the destination cross-check.

Test Plan:
- White rook at (7,0), empty column, allowUp = 7, dst (0,0):
  - done after 10 edges, legal = 1, capture = 0;
  - writes (7,0) <= 000, then (0,0) <= 001.
- White rook at (4,4), black pawn at (4,6), allowRight = 3 (rook block passes through opponents), dst (4,7):
  - blocked at k = 2, done after 4 edges, legal = 0, no wrEn.
- Black rook at (0,7), white king at (0,3), allowLeft = 7, dst (0,3):
  - legal = 1, capture = 1, captureKing = 1;
  - writes (0,7) <= 000, then (0,3) <= 011.
- Diagonal request src (2,2) to dst (5,5):
  - illegal in CHECK, done after 2 edges, legal = 0, no writes.
- Distance exceeds allowance: src (6,3), dst (2,3), allowUp = 2:
  - legal = 0 after 2 edges.
- Reset asserted during SCAN of a d = 6 move:
  - busy, done and wrEn drop asynchronously; state is IDLE;
  - a subsequent start is processed normally.
